// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared ALU widths, select codes, flag and result-entry types.
// Revision : 1.0
// ============================================================================
package alu_pkg;

  localparam int WIDTH   = 32;
  localparam int CTL_W   = 4;
  localparam int NUM_SRC = 5;

  // Select codes of the five result-selector sources
  localparam logic [CTL_W-1:0] SEL_ADD   = 4'd0;
  localparam logic [CTL_W-1:0] SEL_AND   = 4'd1;
  localparam logic [CTL_W-1:0] SEL_OR    = 4'd2;
  localparam logic [CTL_W-1:0] SEL_XOR   = 4'd3;
  localparam logic [CTL_W-1:0] SEL_SHIFT = 4'd4;
  localparam logic [CTL_W-1:0] ARITH_SEL = SEL_ADD;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
  } alu_flags_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [CTL_W-1:0] ctl;
    alu_flags_t       flags;
  } alu_entry_t;

endpackage
`default_nettype wire

// File: rtl/alu_result_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_stage_if
// Purpose  : Upstream/downstream valid-ready bundle of the ALU result stage.
// Revision : 1.0
// ============================================================================
interface alu_result_stage_if #(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int CTL_W = alu_pkg::CTL_W
);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [CTL_W-1:0] in_ctl;
  logic [WIDTH-1:0] in_result;
  logic             in_carry;
  logic             in_ovf;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [CTL_W-1:0] out_ctl;
  logic             out_zero;
  logic             out_neg;
  logic             out_carry;
  logic             out_ovf;

  // master drives results in and consumes them; slave is the stage itself
  modport master (
    output in_valid, in_ctl, in_result, in_carry, in_ovf, out_ready,
    input  in_ready, out_valid, out_result, out_ctl,
           out_zero, out_neg, out_carry, out_ovf
  );

  modport slave (
    input  in_valid, in_ctl, in_result, in_carry, in_ovf, out_ready,
    output in_ready, out_valid, out_result, out_ctl,
           out_zero, out_neg, out_carry, out_ovf
  );

endinterface
`default_nettype wire

// File: rtl/alu_flag_gen.sv
`default_nettype none
// ============================================================================
// Module   : alu_flag_gen
// Purpose  : Illegal-select detection, result masking and status flag derivation.
// Revision : 1.0
// ============================================================================
module alu_flag_gen #(
  parameter int WIDTH     = alu_pkg::WIDTH,
  parameter int CTL_W     = alu_pkg::CTL_W,
  parameter int NUM_SRC   = alu_pkg::NUM_SRC,
  parameter int ARITH_SEL = int'(alu_pkg::ARITH_SEL)
) (
  input  logic [WIDTH-1:0]   result,
  input  logic [CTL_W-1:0]   ctl,
  input  logic               in_carry,
  input  logic               in_ovf,
  output logic               illegal,
  output logic [WIDTH-1:0]   masked_result,
  output alu_pkg::alu_flags_t flags
);
  import alu_pkg::*;

  logic w_arith;

  always_comb begin
    illegal       = (int'(ctl) >= NUM_SRC);
    w_arith       = (ctl == CTL_W'(ARITH_SEL)) && !illegal;
    masked_result = illegal ? '0 : result;
    flags.zero    = (masked_result == '0);
    flags.neg     = masked_result[WIDTH-1];
    // adder carry/overflow only mean something for the arithmetic source
    flags.carry   = w_arith & in_carry;
    flags.ovf     = w_arith & in_ovf;
  end

endmodule
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_stage
// Purpose  : Two-entry registered result buffer after the ALU selector.
// Revision : 1.0
// ============================================================================
module alu_result_stage #(
  parameter int WIDTH     = alu_pkg::WIDTH,
  parameter int CTL_W     = alu_pkg::CTL_W,
  parameter int NUM_SRC   = alu_pkg::NUM_SRC,
  parameter int ARITH_SEL = int'(alu_pkg::ARITH_SEL),
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  alu_result_stage_if.slave  bus,
  output logic               err_ctl,
  output logic [CNT_W-1:0]   acc_count
);
  import alu_pkg::*;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [CTL_W-1:0] ctl;
    alu_flags_t       flags;
  } entry_t;

  entry_t             r_ent0;
  entry_t             r_ent1;
  logic [1:0]         r_occ;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_illegal;
  logic [WIDTH-1:0]   w_masked;
  alu_flags_t         w_flags;
  entry_t             w_new;
  logic               w_accept;
  logic               w_emit;

  alu_flag_gen #(
    .WIDTH     (WIDTH),
    .CTL_W     (CTL_W),
    .NUM_SRC   (NUM_SRC),
    .ARITH_SEL (ARITH_SEL)
  ) u_flag_gen (
    .result        (bus.in_result),
    .ctl           (bus.in_ctl),
    .in_carry      (bus.in_carry),
    .in_ovf        (bus.in_ovf),
    .illegal       (w_illegal),
    .masked_result (w_masked),
    .flags         (w_flags)
  );

  always_comb begin
    w_new.result = w_masked;
    w_new.ctl    = bus.in_ctl;
    w_new.flags  = w_flags;
    w_accept     = bus.in_valid && bus.in_ready;
    w_emit       = bus.out_valid && bus.out_ready;
  end

  // r_ent0 is always the head; it keeps the last emitted entry once drained
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ent0 <= '0;
      r_ent1 <= '0;
      r_occ  <= 2'd0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_emit) begin
        if (r_occ == 2'd2)
          r_ent0 <= r_ent1;
        else if (w_accept)
          r_ent0 <= w_new;
      end else if (w_accept) begin
        if (r_occ == 2'd0)
          r_ent0 <= w_new;
        else
          r_ent1 <= w_new;
      end

      case ({w_accept, w_emit})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase

      if (w_accept && w_illegal)
        r_err <= 1'b1;
      if (w_accept)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready   = (r_occ != 2'd2);
  assign bus.out_valid  = (r_occ != 2'd0);
  assign bus.out_result = r_ent0.result;
  assign bus.out_ctl    = r_ent0.ctl;
  assign bus.out_zero   = r_ent0.flags.zero;
  assign bus.out_neg    = r_ent0.flags.neg;
  assign bus.out_carry  = r_ent0.flags.carry;
  assign bus.out_ovf    = r_ent0.flags.ovf;
  assign err_ctl        = r_err;
  assign acc_count      = r_cnt;

endmodule
`default_nettype wire
